// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples BCLK/LRCLK/ADCDAT in the system clock domain and
// assembles MSB-aligned signed stereo samples, strobing once per L/R pair.
//
// state     | meaning
// SYNC_WAIT | waiting for the first LRCLK transition
// DELAY     | one-bit I2S delay consumed; clear word, latch channel
// SHIFT     | shifting data bits MSB first
// PAD       | word complete, ignoring remaining slot bits
module i2s_rx_deserializer #(
   parameter int SAMPLE_BITS = 24
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i2s_bclk,
   input  logic               i2s_lrclk,
   input  logic               i2s_adcdat,
   input  logic               err_clear,
   output logic signed [31:0] audio_out_L,
   output logic signed [31:0] audio_out_R,
   output logic               audio_valid,
   output logic               frame_error
);

   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      DELAY     = 2'd1,
      SHIFT     = 2'd2,
      PAD       = 2'd3
   } state_t;

   localparam logic [5:0] LAST_BIT = 6'(SAMPLE_BITS - 1);

   state_t                 state_q, state_d;
   logic                   bclk_meta_q, bclk_meta_d;
   logic                   bclk_sync_q, bclk_sync_d;
   logic                   bclk_hist_q, bclk_hist_d;
   logic                   lr_meta_q, lr_meta_d;
   logic                   lr_sync_q, lr_sync_d;
   logic                   dat_meta_q, dat_meta_d;
   logic                   dat_sync_q, dat_sync_d;
   logic                   lr_prev_q, lr_prev_d;
   logic                   chan_q, chan_d;
   logic                   left_ready_q, left_ready_d;
   logic [SAMPLE_BITS-2:0] shift_q, shift_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
   logic [31:0]            out_l_q, out_l_d;
   logic [31:0]            out_r_q, out_r_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;

   logic                   bclk_rise;
   logic                   lr_trans;
   logic                   err_set;
   logic [SAMPLE_BITS-1:0] word;

   function automatic logic [31:0] msb_align(input logic [SAMPLE_BITS-1:0] w);
      msb_align = 32'(w) << (32 - SAMPLE_BITS);
   endfunction

   assign bclk_rise = bclk_sync_q & ~bclk_hist_q;
   assign lr_trans  = lr_sync_q ^ lr_prev_q;
   assign word      = {shift_q, dat_sync_q};

   always_comb begin
      bclk_meta_d  = i2s_bclk;
      bclk_sync_d  = bclk_meta_q;
      bclk_hist_d  = bclk_sync_q;
      lr_meta_d    = i2s_lrclk;
      lr_sync_d    = lr_meta_q;
      dat_meta_d   = i2s_adcdat;
      dat_sync_d   = dat_meta_q;
      state_d      = state_q;
      lr_prev_d    = lr_prev_q;
      chan_d       = chan_q;
      left_ready_d = left_ready_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      left_hold_d  = left_hold_q;
      out_l_d      = out_l_q;
      out_r_d      = out_r_q;
      valid_d      = 1'b0;
      err_set      = 1'b0;

      // DELAY runs on the cycle after the transition edge; lr_prev_q then
      // holds the new word's LRCLK level.
      if (state_q == DELAY) begin
         shift_d   = '0;
         bit_cnt_d = '0;
         chan_d    = lr_prev_q;
         state_d   = SHIFT;
      end else if (bclk_rise) begin
         lr_prev_d = lr_sync_q;
         case (state_q)
            SYNC_WAIT: if (lr_trans) state_d = DELAY;
            SHIFT: begin
               if (lr_trans) begin
                  err_set      = 1'b1;
                  left_ready_d = 1'b0;
                  state_d      = DELAY;
               end else begin
                  shift_d   = word[SAMPLE_BITS-2:0];
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = PAD;
                     if (!chan_q) begin
                        left_hold_d  = word;
                        left_ready_d = 1'b1;
                     end else if (left_ready_q) begin
                        out_l_d      = msb_align(left_hold_q);
                        out_r_d      = msb_align(word);
                        valid_d      = 1'b1;
                        left_ready_d = 1'b0;
                     end
                  end
               end
            end
            PAD:     if (lr_trans) state_d = DELAY;
            default: state_d = SYNC_WAIT;
         endcase
      end

      if (err_set)        err_d = 1'b1;
      else if (err_clear) err_d = 1'b0;
      else                err_d = err_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= SYNC_WAIT;
         bclk_meta_q  <= 1'b0;
         bclk_sync_q  <= 1'b0;
         bclk_hist_q  <= 1'b0;
         lr_meta_q    <= 1'b0;
         lr_sync_q    <= 1'b0;
         dat_meta_q   <= 1'b0;
         dat_sync_q   <= 1'b0;
         lr_prev_q    <= 1'b0;
         chan_q       <= 1'b0;
         left_ready_q <= 1'b0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         left_hold_q  <= '0;
         out_l_q      <= '0;
         out_r_q      <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bclk_meta_q  <= bclk_meta_d;
         bclk_sync_q  <= bclk_sync_d;
         bclk_hist_q  <= bclk_hist_d;
         lr_meta_q    <= lr_meta_d;
         lr_sync_q    <= lr_sync_d;
         dat_meta_q   <= dat_meta_d;
         dat_sync_q   <= dat_sync_d;
         lr_prev_q    <= lr_prev_d;
         chan_q       <= chan_d;
         left_ready_q <= left_ready_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         left_hold_q  <= left_hold_d;
         out_l_q      <= out_l_d;
         out_r_q      <= out_r_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
      end
   end

   assign audio_out_L = out_l_q;
   assign audio_out_R = out_r_q;
   assign audio_valid = valid_q;
   assign frame_error = err_q;

endmodule
